htif_ctrl: RTL

Host-target interface controller for the RV64GC simulation harness. It sits between the instruction-set simulator (ISS) core wrapper and the testbench top. It decodes every 32-bit `tohost` write from the core and gates core stepping through `core_run`. It serves console put-character requests with a ready/valid handshake and acknowledges them on `fromhost`. It also terminates the run on an exit command or a watchdog timeout.

---
 rtl/htif_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/htif_ctrl.sv
// Host-target interface controller: decodes tohost commands, gates core stepping, serves
// console putchar (only when HTIF_CONSOLE_EN is defined) and ends the run on exit or watchdog.
module htif_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             tohost_we,
  input  logic [31:0]      tohost,
  output logic             core_run,
  output logic             con_valid,
  output logic [7:0]       con_data,
  input  logic             con_ready,
  output logic             fromhost_valid,
  output logic [31:0]      fromhost,
  output logic             done,
  output logic             pass,
  output logic [30:0]      exit_code,
  output logic             timeout,
  output logic             bad_cmd,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [31:0] AckWord = 32'h0101_0001;

  typedef enum logic [1:0] {StRun, StConWait, StAck, StDone} state_e;

  state_e           state_q, state_d;
  logic             core_run_q, core_run_d;
  logic             con_valid_q, con_valid_d;
  logic [7:0]       con_data_q, con_data_d;
  logic             fromhost_valid_q, fromhost_valid_d;
  logic [31:0]      fromhost_q, fromhost_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [30:0]      exit_code_q, exit_code_d;
  logic             timeout_q, timeout_d;
  logic             bad_cmd_q, bad_cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]  dev, cmd;
  logic        is_null, is_exit, is_put;
  logic [63:0] cnt_wide;
  logic        cnt_hit;

  assign dev     = tohost[31:24];
  assign cmd     = tohost[23:16];
  assign is_null = (tohost == 32'h0);
  assign is_exit = (dev == 8'h00) && (cmd == 8'h00) && tohost[0];

`ifdef HTIF_CONSOLE_EN
  assign is_put = (dev == 8'h01) && (cmd == 8'h01);
`else
  assign is_put = 1'b0;
`endif

  // Counter advances on every edge taken in RUN, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StRun && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_wide = 64'(cnt_d);
  assign cnt_hit  = (TIMEOUT_CYCLES != 0) && (cnt_wide == 64'(TIMEOUT_CYCLES));

  always_comb begin
    state_d          = state_q;
    con_valid_d      = con_valid_q;
    con_data_d       = con_data_q;
    fromhost_valid_d = 1'b0;
    fromhost_d       = fromhost_q;
    done_d           = done_q;
    pass_d           = pass_q;
    exit_code_d      = exit_code_q;
    timeout_d        = timeout_q;
    bad_cmd_d        = bad_cmd_q;

    unique case (state_q)
      StRun: begin
        // An exit write beats a watchdog expiry on the same edge.
        if (tohost_we && is_exit) begin
          exit_code_d = tohost[31:1];
          pass_d      = (tohost[31:1] == 31'h0);
          done_d      = 1'b1;
          state_d     = StDone;
        end else begin
          if (tohost_we && !is_null && !is_put) begin
            bad_cmd_d = 1'b1;
          end
          if (cnt_hit) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            state_d   = StDone;
          end else if (tohost_we && is_put) begin
            con_data_d  = tohost[7:0];
            con_valid_d = 1'b1;
            state_d     = StConWait;
          end
        end
      end
      StConWait: begin
        if (tohost_we) begin
          bad_cmd_d = 1'b1;
        end
        if (con_ready) begin
          con_valid_d      = 1'b0;
          fromhost_valid_d = 1'b1;
          fromhost_d       = AckWord;
          state_d          = StAck;
        end
      end
      StAck: begin
        if (tohost_we) begin
          bad_cmd_d = 1'b1;
        end
        state_d = StRun;
      end
      StDone: begin
        if (tohost_we) begin
          bad_cmd_d = 1'b1;
        end
      end
    endcase

    core_run_d = (state_d == StRun);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q          <= StRun;
      core_run_q       <= 1'b1;
      con_valid_q      <= 1'b0;
      con_data_q       <= 8'h00;
      fromhost_valid_q <= 1'b0;
      fromhost_q       <= 32'h0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      exit_code_q      <= 31'h0;
      timeout_q        <= 1'b0;
      bad_cmd_q        <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      core_run_q       <= core_run_d;
      con_valid_q      <= con_valid_d;
      con_data_q       <= con_data_d;
      fromhost_valid_q <= fromhost_valid_d;
      fromhost_q       <= fromhost_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      exit_code_q      <= exit_code_d;
      timeout_q        <= timeout_d;
      bad_cmd_q        <= bad_cmd_d;
      cnt_q            <= cnt_d;
    end
  end

  assign core_run  = core_run_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign exit_code = exit_code_q;
  assign timeout   = timeout_q;
  assign bad_cmd   = bad_cmd_q;
  assign cycle_cnt = cnt_q;

`ifdef HTIF_CONSOLE_EN
  assign con_valid      = con_valid_q;
  assign con_data       = con_data_q;
  assign fromhost_valid = fromhost_valid_q;
  assign fromhost       = fromhost_q;
`else
  logic unused_con;
  assign unused_con     = ^{con_valid_q, con_data_q, fromhost_valid_q, fromhost_q};
  assign con_valid      = 1'b0;
  assign con_data       = 8'h00;
  assign fromhost_valid = 1'b0;
  assign fromhost       = 32'h0;
`endif

endmodule
